// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - operation encodings carried on op_e
//   - sequencer state encoding
//   - default multiplier pipeline latency
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MULT_LAT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_MCAP = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
// Bundle between the sequencer and the two arithmetic units.
//   multiplier: mult_ce, mult_sign, mult_sclr  (ctrl -> unit), mult_result (unit -> ctrl)
//   divider   : div_opn_valid, div_sign, div_res_ready, div_abort (ctrl -> unit),
//               div_res_valid, div_result (unit -> ctrl)
// master = sequencer side, slave = arithmetic unit side.
interface muldiv_ctrl_if;

    logic        mult_ce;
    logic        mult_sign;
    logic        mult_sclr;
    logic [63:0] mult_result;

    logic        div_opn_valid;
    logic        div_sign;
    logic        div_res_ready;
    logic        div_abort;
    logic        div_res_valid;
    logic [63:0] div_result;

    modport master (
        output mult_ce, mult_sign, mult_sclr,
        output div_opn_valid, div_sign, div_res_ready, div_abort,
        input  mult_result, div_res_valid, div_result
    );

    modport slave (
        input  mult_ce, mult_sign, mult_sclr,
        input  div_opn_valid, div_sign, div_res_ready, div_abort,
        output mult_result, div_res_valid, div_result
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Sequences the pipelined multiplier and the iterative divider for the EX
// stage, generates the EX stall and holds the 64-bit {HI,LO} result until
// the M stage takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation in flight; a valid mult/div in EX issues here
// MULT  | multiplier clocking, cnt counts CE cycles
// MCAP  | product valid, captured into res_q
// DIV   | waiting for divider result handshake
// DONE  | res_q presented to M, held while stall_m
//
// Ports:
//   clk, resetn           clock, async active-low reset
//   op_valid_e, op_e      EX instruction valid and mult/div opcode
//   flush_e               kill EX instruction (highest priority)
//   flush_exception_m     exception flush from M, masks stall_e
//   stall_m               M stalled, hold result in DONE
//   mdu                   multiplier/divider bundle (master side)
//   stall_e               stall EX and earlier
//   result_e              held {HI,LO}, zero outside DONE
//   result_valid_e        result_e valid this cycle
//
// CNT_W must satisfy 2**CNT_W > MULT_LAT.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid_e,
    input  logic [1:0]    op_e,
    input  logic          flush_e,
    input  logic          flush_exception_m,
    input  logic          stall_m,
    muldiv_ctrl_if.master mdu,
    output logic          stall_e,
    output logic [63:0]   result_e,
    output logic          result_valid_e
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        res_q;

    logic busy;
    logic abort;
    logic issue;
    logic cnt_tc;

    logic ce_raw;
    logic dov_raw;
    logic rdy_raw;
    logic stall_raw;

    assign busy   = (state == ST_MULT) || (state == ST_MCAP) || (state == ST_DIV);
    // EX dropping its instruction mid-operation is handled exactly like a flush.
    assign abort  = flush_e | (busy & ~op_valid_e);
    assign issue  = (state == ST_IDLE) & op_valid_e & ~flush_e;
    assign cnt_tc = (cnt == CNT_W'(MULT_LAT - 1));

    always_comb begin
        ce_raw         = 1'b0;
        dov_raw        = 1'b0;
        rdy_raw        = 1'b0;
        stall_raw      = 1'b0;
        result_valid_e = 1'b0;
        result_e       = '0;
        case (state)
            ST_IDLE: begin
                ce_raw    = issue & ~op_e[1];
                dov_raw   = issue & op_e[1];
                stall_raw = issue;
            end
            ST_MULT: begin
                ce_raw    = ~abort;
                stall_raw = ~abort;
            end
            ST_MCAP: begin
                stall_raw = ~abort;
            end
            ST_DIV: begin
                dov_raw   = ~abort;
                rdy_raw   = mdu.div_res_valid & ~abort;
                stall_raw = ~abort;
            end
            ST_DONE: begin
                result_valid_e = 1'b1;
                result_e       = res_q;
            end
            default: ;
        endcase
    end

    // During reset the state is IDLE and res_q is zero, so only the unit
    // controls need explicit gating; stall_e keeps following the EX inputs.
    assign mdu.mult_ce       = ce_raw & resetn;
    assign mdu.div_opn_valid = dov_raw & resetn;
    assign mdu.div_res_ready = rdy_raw & resetn;
    assign mdu.mult_sclr     = abort & resetn;
    assign mdu.div_abort     = abort & resetn;
    assign mdu.mult_sign     = (op_e == OP_MULT) & resetn;
    assign mdu.div_sign      = (op_e == OP_DIV) & resetn;
    assign stall_e           = stall_raw & ~flush_exception_m;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            res_q <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid_e) begin
                        if (op_e[1]) begin
                            state <= ST_DIV;
                        end else begin
                            state <= ST_MULT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_MULT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_tc) state <= ST_MCAP;
                end
                ST_MCAP: begin
                    res_q <= mdu.mult_result;
                    state <= ST_DONE;
                end
                ST_DIV: begin
                    if (mdu.div_res_valid) begin
                        res_q <= mdu.div_result;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall_m) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multi-cycle units of the EX stage: the pipelined multiplier (fixed latency, CE/SCLR controlled) and the iterative divider (valid/ready handshake). It issues the operation and generates the EX stall. It holds the 64-bit {HI,LO} result in a register until the M stage accepts it, and aborts cleanly on flush. It sits beside the ALU and replaces the ad-hoc counter and stall logic for multiply and divide.

## Interface
Parameters:
- MULT_LAT, 8: number of CE-asserted cycles before the multiplier product is valid.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > MULT_LAT.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- op_valid_e  in  1  EX holds a mult/div instruction
- op_e  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- flush_e  in  1  kill the EX instruction
- flush_exception_m  in  1  exception flush from M
- stall_m  in  1  M stage stalled; result must be held
- mult_result  in  64  multiplier P output
- div_res_valid  in  1  divider result valid
- div_result  in  64  divider result {rem,quot}
- mult_ce  out  1  multiplier clock enable
- mult_sign  out  1  1 = signed multiply
- mult_sclr  out  1  multiplier synchronous clear
- div_opn_valid  out  1  divider operation valid
- div_sign  out  1  1 = signed divide
- div_res_ready  out  1  divider result accepted
- div_abort  out  1  divider reset request
- stall_e  out  1  stall EX and earlier stages
- result_e  out  64  held {HI,LO} result
- result_valid_e  out  1  result_e is valid this cycle

## Operation
- States: IDLE, MULT, MCAP, DIV, DONE. Counter cnt is CNT_W bits. Hold register res_q is 64 bits.
- IDLE:
  - op_valid_e & op_e[1]=0: mult_ce=1, stall_e=1, cnt<=1, next state MULT.
  - op_valid_e & op_e[1]=1: div_opn_valid=1, stall_e=1, next state DIV.
- MULT: mult_ce=1, stall_e=1, cnt<=cnt+1. When cnt==MULT_LAT-1, next state MCAP.
- MCAP: mult_ce=0, stall_e=1, res_q<=mult_result, next state DONE.
- DIV: div_opn_valid=1, stall_e=1.
  - On div_res_valid: div_res_ready=1 in the same cycle, res_q<=div_result, next state DONE.
- DONE: stall_e=0, result_valid_e=1, result_e=res_q.
  - stall_m=1: stay in DONE.
  - stall_m=0: next state IDLE.
- A new instruction entering EX is issued in its first cycle in IDLE, so back-to-back mult/div incurs no bubble.
- Sign outputs are decoded combinationally from the current op_e and are valid whenever ce or opn_valid is high: mult_sign = op_e==00, div_sign = op_e==10.
- flush_e has highest priority, in any state:
  - next state IDLE, cnt<=0, res_q unchanged.
  - mult_sclr=1 and div_abort=1 in the flush cycle.
  - No issue occurs in that cycle.
- op_valid_e falling while in MULT/MCAP/DIV is treated as flush_e.
- flush_exception_m forces stall_e=0 combinationally. It does not change state; flush_e accompanies it.
- result_e is zero in every state other than DONE.

## Timing
- Reset (resetn low, asynchronous): state IDLE, cnt 0, res_q 0.
- Output values during reset: all outputs 0, except stall_e, which follows op_valid_e & ~flush_exception_m & ~flush_e.
- Multiply: stall_e is high for MULT_LAT+1 cycles (MULT_LAT with CE, plus 1 capture cycle). DONE follows in the next cycle.
- Divide: stall_e is high from the issue cycle through the div_res_valid cycle inclusive. DONE follows in the next cycle.
- div_res_ready is asserted for exactly one cycle per operation.
- In DONE, result_e and result_valid_e stay stable for as long as stall_m is held.
- A flush and a div_res_valid in the same cycle: the flush wins; the result is discarded and div_res_ready=0.
- resetn asserted mid-operation: immediate return to IDLE. The units are cleared via their own reset.

## Structure
- muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum;
  - the default MULT_LAT.
- No sub-module. The counter, FSM and hold register live in one module, roughly 150–200 lines.

## Test plan
- MULT issue with MULT_LAT=8, mult_result model = 0x00000001_FFFFFFFE:
  - stall_e high for 9 cycles; mult_ce high for 8;
  - DONE has result_e=0x00000001_FFFFFFFE and result_valid_e=1 for 1 cycle.
- DIVU issue, div_res_valid at cycle 33, div_result=0x3_5:
  - div_res_ready pulses in cycle 33;
  - stall_e falls in cycle 34;
  - result_e=0x00000003_00000005.
- DONE with stall_m held 3 cycles: result_valid_e and result_e are stable for 4 cycles; then IDLE.
- Back-to-back MULT then DIV (op_valid_e continuous): DIV issue (div_opn_valid=1) occurs in the cycle after DONE, with no idle gap.
- flush_e in MULT cycle 4: mult_sclr=1 and state IDLE next cycle. A following MULT restarts with cnt=1 and a full 9-cycle stall.
- resetn low during DIV: all outputs 0 immediately. After release, IDLE and result_e=0.
